// File: rtl/alu64.sv
// 64-bit integer ALU with combinational result/zero and a
// registered NZCV flag register loaded on flag-setting instructions.
module alu64 (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [4:0]  ALUControl,
    input  logic        flags_we,
    output logic [63:0] result,
    output logic        zero,
    output logic [3:0]  flags
);

    typedef enum logic [4:0] {
        OP_AND  = 5'b00000,
        OP_OR   = 5'b00001,
        OP_ADD  = 5'b00010,
        OP_EOR  = 5'b00011,
        OP_SUB  = 5'b00110,
        OP_PASS = 5'b00111,
        OP_LSL  = 5'b01000,
        OP_LSR  = 5'b01001,
        OP_NOR  = 5'b01100
    } alu_op_t;

    logic        is_add;
    logic        is_sub;
    logic        is_arith;
    logic [63:0] add_b;
    logic [63:0] sum;
    logic        carry;
    logic [5:0]  shamt;
    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;
    logic [3:0]  next_flags;

    assign is_add   = (ALUControl == OP_ADD);
    assign is_sub   = (ALUControl == OP_SUB);
    assign is_arith = is_add | is_sub;

    // One adder serves both ADD and SUB: a + ~b + 1 for subtraction.
    assign add_b = is_sub ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, add_b} + {64'd0, is_sub};

    assign shamt = b[5:0];

    always_comb begin
        result = 64'd0;
        unique case (ALUControl)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = sum;
            OP_EOR:  result = a ^ b;
            OP_SUB:  result = sum;
            OP_PASS: result = b;
            OP_LSL:  result = a << shamt;
            OP_LSR:  result = a >> shamt;
            OP_NOR:  result = ~(a | b);
            default: result = 64'd0;
        endcase
    end

    assign zero = (result == 64'd0);

    // Overflow: operand signs as seen by the adder agree, result sign differs.
    always_comb begin
        flag_n = result[63];
        flag_z = zero;
        flag_c = 1'b0;
        flag_v = 1'b0;
        if (is_arith) begin
            flag_c = carry;
            flag_v = (a[63] == add_b[63]) && (sum[63] != a[63]);
        end
    end

    assign next_flags = {flag_n, flag_z, flag_c, flag_v};

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (flags_we) begin
            flags <= next_flags;
        end
    end

endmodule

// File: tb/tb_alu64.sv
// Directed self-checking bench for alu64: operation sweeps,
// zero detection, shifts and the NZCV flag register.
module tb_alu64;

    logic        clk;
    logic        reset;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  alu_ctl;
    logic        flags_we;
    logic [63:0] result;
    logic        zero;
    logic [3:0]  flags;

    int checks = 0;
    int failures = 0;

    localparam logic [4:0] C_AND  = 5'b00000;
    localparam logic [4:0] C_OR   = 5'b00001;
    localparam logic [4:0] C_ADD  = 5'b00010;
    localparam logic [4:0] C_EOR  = 5'b00011;
    localparam logic [4:0] C_SUB  = 5'b00110;
    localparam logic [4:0] C_PASS = 5'b00111;
    localparam logic [4:0] C_LSL  = 5'b01000;
    localparam logic [4:0] C_LSR  = 5'b01001;
    localparam logic [4:0] C_NOR  = 5'b01100;

    alu64 dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .ALUControl (alu_ctl),
        .flags_we   (flags_we),
        .result     (result),
        .zero       (zero),
        .flags      (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [4:0] op, input logic [63:0] va,
                         input logic [63:0] vb);
        alu_ctl = op;
        a = va;
        b = vb;
        #1;
    endtask

    task automatic sweep_ops(input logic [63:0] va, input logic [63:0] vb,
                             input string grp);
        logic [63:0] e;
        apply(C_AND, va, vb);
        e = va & vb;
        chk({grp, "_and"}, result, e);
        chk({grp, "_and_z"}, {63'd0, zero}, {63'd0, e == 64'd0});
        apply(C_OR, va, vb);
        e = va | vb;
        chk({grp, "_or"}, result, e);
        apply(C_ADD, va, vb);
        e = va + vb;
        chk({grp, "_add"}, result, e);
        apply(C_SUB, va, vb);
        e = va - vb;
        chk({grp, "_sub"}, result, e);
        chk({grp, "_sub_z"}, {63'd0, zero}, {63'd0, e == 64'd0});
        apply(C_PASS, va, vb);
        chk({grp, "_pass"}, result, vb);
        apply(C_NOR, va, vb);
        e = ~(va | vb);
        chk({grp, "_nor"}, result, e);
    endtask

    task automatic load_flags(input string tag, input logic [4:0] op,
                              input logic [63:0] va, input logic [63:0] vb,
                              input logic [3:0] exp);
        apply(op, va, vb);
        flags_we = 1'b1;
        @(posedge clk);
        #1;
        flags_we = 1'b0;
        chk(tag, {60'd0, flags}, {60'd0, exp});
    endtask

    initial begin
        reset = 1'b1;
        flags_we = 1'b0;
        alu_ctl = C_AND;
        a = 64'd0;
        b = 64'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_flags", {60'd0, flags}, 64'd0);
        reset = 1'b0;

        // Worked examples
        apply(C_AND, 64'd6, 64'd3);
        chk("ex_and", result, 64'd2);
        apply(C_OR, 64'd6, 64'd3);
        chk("ex_or", result, 64'd7);
        apply(C_ADD, 64'd6, 64'd3);
        chk("ex_add", result, 64'd9);
        apply(C_SUB, 64'd6, 64'd3);
        chk("ex_sub", result, 64'd3);
        apply(C_PASS, 64'd6, 64'd3);
        chk("ex_pass", result, 64'd3);
        apply(C_NOR, 64'd6, 64'd3);
        chk("ex_nor", result, 64'hFFFF_FFFF_FFFF_FFF8);
        apply(C_ADD, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("ex_add_neg", result, 64'hFFFF_FFFF_FFFF_FFFF);
        apply(C_SUB, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("ex_sub_neg", result, 64'd5);

        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 10; j++) begin
                sweep_ops(64'(i), 64'(j), "pos");
                sweep_ops(64'(i), 64'd0 - 64'(j), "mix");
            end
        end

        // Zero detection
        apply(C_SUB, 64'd7, 64'd7);
        chk("z_sub_res", result, 64'd0);
        chk("z_sub", {63'd0, zero}, 64'd1);
        apply(C_PASS, 64'd9, 64'd0);
        chk("z_pass", {63'd0, zero}, 64'd1);
        apply(C_OR, 64'd1, 64'd0);
        chk("z_or", {63'd0, zero}, 64'd0);
        apply(5'b11111, 64'd123, 64'd456);
        chk("undef_res", result, 64'd0);
        chk("undef_z", {63'd0, zero}, 64'd1);
        apply(5'b00100, 64'hFF, 64'hFF);
        chk("undef4_res", result, 64'd0);

        // Shifts and EOR
        apply(C_LSL, 64'd1, 64'd63);
        chk("lsl63", result, 64'h8000_0000_0000_0000);
        apply(C_LSL, 64'h0000_0000_0000_00F0, 64'hFFFF_FFFF_FFFF_FF04);
        chk("lsl_hi_ign", result, 64'h0000_0000_0000_0F00);
        apply(C_LSR, 64'h8000_0000_0000_0000, 64'h40);
        chk("lsr0", result, 64'h8000_0000_0000_0000);
        apply(C_LSR, 64'h8000_0000_0000_0000, 64'd63);
        chk("lsr63", result, 64'd1);
        apply(C_LSR, 64'hF000_0000_0000_0000, 64'd4);
        chk("lsr_fill", result, 64'h0F00_0000_0000_0000);
        apply(C_EOR, 64'hA5, 64'hA5);
        chk("eor_res", result, 64'd0);
        chk("eor_z", {63'd0, zero}, 64'd1);
        apply(C_EOR, 64'hA5, 64'h5A);
        chk("eor_ff", result, 64'hFF);

        // Flag register
        load_flags("f_add_ovf", C_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001);
        load_flags("f_add_cry", C_ADD, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'hFFFF_FFFF_FFFF_FFFF, 4'b1010);
        load_flags("f_sub_eq", C_SUB, 64'd5, 64'd5, 4'b0110);
        load_flags("f_sub_lt", C_SUB, 64'd3, 64'd5, 4'b1000);
        load_flags("f_sub_ovf", C_SUB, 64'h8000_0000_0000_0000, 64'd1, 4'b0011);
        load_flags("f_and", C_AND, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'h8000_0000_0000_0000, 4'b1000);
        load_flags("f_reload", C_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001);

        apply(C_SUB, 64'd5, 64'd5);
        @(posedge clk);
        #1;
        chk("f_hold", {60'd0, flags}, 64'b1001);

        reset = 1'b1;
        flags_we = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        flags_we = 1'b0;
        chk("f_reset_pri", {60'd0, flags}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu64.md
# alu64

Combinational 64-bit integer ALU for the single-cycle datapath, with a registered NZCV condition-flag register. It sits between the register file and the write-back / data-memory address path. It produces `result` and `zero` in the same cycle as its operands. It also captures the flags on a clock edge when the datapath executes a flag-setting instruction.

## Interface
- No parameters; data width fixed at 64.
- `clk`  input  1  single clock; flag register samples on the rising edge.
- `reset`  input  1  synchronous, active-high; clears the flag register.
- `a`  input  64  operand A (register Rn).
- `b`  input  64  operand B (Rm or extended immediate).
- `ALUControl`  input  5  operation select.
- `flags_we`  input  1  when 1, NZCV is loaded at the next rising edge.
- `result`  output  64  operation result, combinational.
- `zero`  output  1  1 iff `result == 64'h0`, combinational.
- `flags`  output  4  registered {N,Z,C,V}, bit 3 = N.

## Operation
- Operation select, by `ALUControl`:
  - 5'b00000 AND: `a & b`.
  - 5'b00001 OR: `a | b`.
  - 5'b00010 ADD: `a + b`, modulo 2^64.
  - 5'b00011 EOR: `a ^ b`.
  - 5'b00110 SUB: `a - b`, computed as `a + ~b + 1`, modulo 2^64.
  - 5'b00111 PASS B: `b`.
  - 5'b01000 LSL: `a << b[5:0]`.
  - 5'b01001 LSR: `a >> b[5:0]`, logical, zero fill.
  - 5'b01100 NOR: `~(a | b)`.
  - All other codes: `result = 0`, so `zero = 1`.
- Operands are two's complement; ADD/SUB results are the same bit pattern signed or unsigned. Wrap-around is silent and no exception is raised.
- Shifts use only `b[5:0]`; upper bits of `b` are ignored. A shift amount of 0 returns `a`.
- `zero` reflects the current `result` for every opcode, including PASS B and undefined codes.
- Next-flag computation, combinational:
  - N = `result[63]`.
  - Z = `zero`.
  - ADD: C = carry-out of bit 63; V = (`a[63]==b[63]`) && (`result[63]!=a[63]`).
  - SUB: C = carry-out of `a + ~b + 1`, i.e. 1 when no borrow (`a >= b` unsigned); V = (`a[63]!=b[63]`) && (`result[63]!=a[63]`).
  - All other opcodes: C = 0, V = 0.

## Timing
- `result` and `zero` are purely combinational from `a`, `b`, `ALUControl`, with zero-cycle latency. They must settle within one clock period and do not depend on `clk` or `reset`.
- `flags` updates only at the rising edge of `clk`:
  - If `reset` = 1: `flags` ← 4'b0000. Reset has priority over `flags_we`.
  - Else if `flags_we` = 1: `flags` ← next NZCV computed from the current inputs.
  - Else: `flags` holds.
- Reset value: `flags` = 4'b0000. `result`/`zero` have no reset state; they follow the inputs during reset.
- Asserting `reset` while `flags_we` = 1 clears the flags; no write occurs that cycle.
- Changing inputs between edges has no effect on `flags` until the next enabled edge.

## Test plan
- Logic/pass sweep: for `a` in 0..9 and `b` in 0..9, apply AND, OR, ADD, SUB, PASS B, NOR and compare against the same 64-bit expression. Example: a=6, b=3 gives AND=2, OR=7, ADD=9, SUB=3, PASS=3, NOR=64'hFFFF_FFFF_FFFF_FFF8. Zero errors required.
- Mixed-sign sweep: `a` in 0..9, `b` in 0..-9 (sign-extended to 64 bits), same six ops. Examples:
  - a=2, b=-3: ADD = 64'hFFFF_FFFF_FFFF_FFFF, SUB = 5.
  - a=0, b=0: AND = 0 with `zero` = 1.
- Zero flag: SUB with a=b=7 gives result 0 and `zero` = 1. PASS B with b=0 gives `zero` = 1. OR with a=1, b=0 gives `zero` = 0. Undefined code 5'b11111 gives result 0 and `zero` = 1.
- Flags/overflow: with `flags_we` = 1, clock each case and check `flags`:
  - ADD a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → NZCV = 1001.
  - ADD a=b=64'hFFFF_FFFF_FFFF_FFFF → 1010.
  - SUB a=5, b=5 → 0110.
  - SUB a=3, b=5 → 1000.
- Flag hold/reset: after loading 1001, set `flags_we` = 0 and change the inputs; `flags` stays 1001. Then assert `reset` together with `flags_we` = 1 for one edge; `flags` = 0000.
- Shifts: LSL a=1, b=63 → 64'h8000_0000_0000_0000. LSR a=64'h8000_0000_0000_0000, b=64'h40 (b[5:0]=0) → unchanged. EOR a=b=64'hA5 → 0 with `zero` = 1.
